spi_packet_tx: RTL

- SPI initiator that serialises one tone-generator configuration packet of PACKET_SIZE*NUM_TRACKS bits, MSB first, onto cs/sck/sdi.
- Drives the existing SPI receiver in the tone-generator top level.
- Sits between the control/sequencer logic, which supplies packets via start/packet_in, and the receiver pins.
- cs is high for the whole frame; its falling edge marks the packet complete and is where the receiver latches.

---
 rtl/spi_packet_tx.sv | 129 ++++++++++++
 1 files changed

// File: rtl/spi_packet_tx.sv
// SPI initiator: serialises one tone-generator configuration packet MSB first
// on cs/sck/sdi, framing it with cs high and a trailing CLK_DIV-cycle tail.
module spi_packet_tx #(
    parameter int NUM_TRACKS  = 1,
    parameter int PACKET_SIZE = 24,
    parameter int CLK_DIV     = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic [PACKET_SIZE*NUM_TRACKS-1:0] packet_in,
    output logic                              busy,
    output logic                              done,
    output logic                              cs,
    output logic                              sck,
    output logic                              sdi
);

    // state | meaning
    // IDLE  | waiting for start; done pulses here for one cycle after TAIL
    // LOW   | sck low, sdi set up for the coming rising edge
    // HIGH  | sck high, receiver samples sdi on entry to this state
    // TAIL  | cs held high with sck low before cs falls and the receiver latches

    localparam int N  = PACKET_SIZE * NUM_TRACKS;
    localparam int BW = (N > 1) ? $clog2(N) : 1;
    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        TAIL = 2'd3
    } state_t;

    state_t          state_q;
    logic [N-1:0]    sreg_q;
    logic [BW-1:0]   bit_q;
    logic [PW-1:0]   phase_q;
    logic            busy_q;
    logic            done_q;
    logic            cs_q;
    logic            sck_q;
    logic            sdi_q;

    logic [N-1:0]    sreg_d;
    logic            phase_last;
    logic            bit_last;

    // Shifted copy is used so the next bit is taken from bit N-1 even when N=1.
    assign sreg_d     = sreg_q << 1;
    assign phase_last = (phase_q == PW'(CLK_DIV - 1));
    assign bit_last   = (bit_q == BW'(N - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            bit_q   <= '0;
            phase_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cs_q    <= 1'b0;
            sck_q   <= 1'b0;
            sdi_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        sreg_q  <= packet_in;
                        cs_q    <= 1'b1;
                        busy_q  <= 1'b1;
                        sck_q   <= 1'b0;
                        sdi_q   <= packet_in[N-1];
                        bit_q   <= '0;
                        phase_q <= '0;
                        state_q <= LOW;
                    end
                end
                LOW: begin
                    if (phase_last) begin
                        sck_q   <= 1'b1;
                        phase_q <= '0;
                        state_q <= HIGH;
                    end else begin
                        phase_q <= phase_q + 1'b1;
                    end
                end
                HIGH: begin
                    if (phase_last) begin
                        sck_q   <= 1'b0;
                        phase_q <= '0;
                        if (!bit_last) begin
                            sreg_q  <= sreg_d;
                            sdi_q   <= sreg_d[N-1];
                            bit_q   <= bit_q + 1'b1;
                            state_q <= LOW;
                        end else begin
                            sdi_q   <= 1'b0;
                            state_q <= TAIL;
                        end
                    end else begin
                        phase_q <= phase_q + 1'b1;
                    end
                end
                TAIL: begin
                    if (phase_last) begin
                        cs_q    <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        phase_q <= '0;
                        state_q <= IDLE;
                    end else begin
                        phase_q <= phase_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign cs   = cs_q;
    assign sck  = sck_q;
    assign sdi  = sdi_q;

endmodule
